// File: rtl/spi_seq_pkg.sv
// ============================================================================
// Module  : spi_seq_pkg
// Purpose : Shared state encoding and helpers for the SPI stream sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package spi_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2
   } seq_state_t;

   // Bit counter must be able to hold DATA_W itself (frame-complete marker).
   function automatic int bitcnt_w(input int dataW);
      return $clog2(dataW + 1);
   endfunction

   // Wraps to startA after endA; callers truncate to their address width.
   function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                             input logic [31:0] endA,
                                             input logic [31:0] startA);
      return (addr == endA) ? startA : addr + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shift_out.sv
// ============================================================================
// Module  : spi_shift_out
// Purpose : MSB-first SPI mode-0 shifter driven by sclk edge strobes.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module spi_shift_out
   import spi_seq_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  logic              clk,
   input  logic              resetN,
   input  logic              en_i,
   input  logic              load_i,
   input  logic              clr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              posEdge_i,
   input  logic              negEdge_i,
   output logic              mosi_o,
   output logic              frameDone_o
);

   localparam int                BITCNT_W = bitcnt_w(DATA_W);
   localparam logic [BITCNT_W-1:0] C_FULL = BITCNT_W'(DATA_W);

   logic [DATA_W-1:0]   shReg_q;
   logic [BITCNT_W-1:0] bitCnt_q;
   logic                mosi_q;

   assign mosi_o      = mosi_q;
   assign frameDone_o = en_i && negEdge_i && (bitCnt_q == C_FULL);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         shReg_q  <= '0;
         bitCnt_q <= '0;
         mosi_q   <= 1'b0;
      end else if (load_i) begin
         shReg_q  <= data_i;
         bitCnt_q <= '0;
         mosi_q   <= data_i[DATA_W-1];
      end else if (clr_i) begin
         bitCnt_q <= '0;
         mosi_q   <= 1'b0;
      end else if (en_i) begin
         if (posEdge_i && (bitCnt_q != C_FULL))
            bitCnt_q <= bitCnt_q + 1'b1;
         // Bit 0 of the counter range means the MSB has not been sampled yet.
         if (negEdge_i && (bitCnt_q != '0) && (bitCnt_q != C_FULL)) begin
            shReg_q <= {shReg_q[DATA_W-2:0], 1'b0};
            mosi_q  <= shReg_q[DATA_W-2];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/spi_stream_sequencer.sv
// ============================================================================
// Module  : spi_stream_sequencer
// Purpose : Streams memory bytes startAddr..endAddr gap-free over SPI mode 0.
//           Optional looping is enabled by defining SPI_SEQ_LOOP_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module spi_stream_sequencer
   import spi_seq_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int MEM_LAT = 1
)(
   input  logic              clk,
   input  logic              resetN,
   input  logic              sclkPosEdge,
   input  logic              sclkNegEdge,
   input  logic              start,
   input  logic              stop,
`ifdef SPI_SEQ_LOOP_EN
   input  logic              loopEn,
`endif
   input  logic [ADDR_W-1:0] startAddr,
   input  logic [ADDR_W-1:0] endAddr,
   output logic [ADDR_W-1:0] memAddr,
   output logic              memRdEn,
   input  logic [DATA_W-1:0] memData,
   output logic              mosi,
   output logic              csN,
   output logic              busy,
   output logic              done
);

   seq_state_t         state_q;
   logic [ADDR_W-1:0]  startAddr_q, endAddr_q, curAddr_q, memAddr_q;
   logic [MEM_LAT-1:0] rdVld_q;
   logic [DATA_W-1:0]  pfData_q;
   logic               memRdEn_q, csN_q, busy_q, done_q, stopPend_q, loop_q;

   logic               loopReq_d, dataVld_d, frameDone_d, lastFrame_d, noPf_d;
   logic               load_d, clr_d;
   logic [ADDR_W-1:0]  nextAddr_d;
   logic [DATA_W-1:0]  loadData_d;

`ifdef SPI_SEQ_LOOP_EN
   assign loopReq_d = loopEn;
`else
   assign loopReq_d = 1'b0;
`endif

   assign dataVld_d   = rdVld_q[MEM_LAT-1];
   assign nextAddr_d  = ADDR_W'(next_addr(32'(memAddr_q), 32'(endAddr_q), 32'(startAddr_q)));
   assign lastFrame_d = (!loop_q && (curAddr_q == endAddr_q)) || stopPend_q || stop;
   // One-shot streams never read beyond endAddr.
   assign noPf_d      = !loop_q && (memAddr_q == endAddr_q);
   assign load_d      = ((state_q == FETCH) && dataVld_d) || (frameDone_d && !lastFrame_d);
   assign clr_d       = frameDone_d && lastFrame_d;
   assign loadData_d  = (state_q == FETCH) ? memData : pfData_q;

   assign memAddr = memAddr_q;
   assign memRdEn = memRdEn_q;
   assign csN     = csN_q;
   assign busy    = busy_q;
   assign done    = done_q;

   spi_shift_out #(.DATA_W(DATA_W)) u_shift (
      .clk         (clk),
      .resetN      (resetN),
      .en_i        (state_q == SHIFT),
      .load_i      (load_d),
      .clr_i       (clr_d),
      .data_i      (loadData_d),
      .posEdge_i   (sclkPosEdge),
      .negEdge_i   (sclkNegEdge),
      .mosi_o      (mosi),
      .frameDone_o (frameDone_d)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE;
         startAddr_q <= '0;
         endAddr_q   <= '0;
         curAddr_q   <= '0;
         memAddr_q   <= '0;
         rdVld_q     <= '0;
         pfData_q    <= '0;
         memRdEn_q   <= 1'b0;
         csN_q       <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         stopPend_q  <= 1'b0;
         loop_q      <= 1'b0;
      end else begin
         memRdEn_q <= 1'b0;
         done_q    <= 1'b0;
         rdVld_q   <= MEM_LAT'({rdVld_q, memRdEn_q});
         case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  startAddr_q <= startAddr;
                  endAddr_q   <= endAddr;
                  loop_q      <= loopReq_d;
                  memAddr_q   <= startAddr;
                  memRdEn_q   <= 1'b1;
                  busy_q      <= 1'b1;
                  stopPend_q  <= 1'b0;
                  state_q     <= FETCH;
               end
            end
            FETCH: begin
               if (stop) stopPend_q <= 1'b1;
               if (dataVld_d) begin
                  csN_q     <= 1'b0;
                  curAddr_q <= memAddr_q;
                  if (!noPf_d) begin
                     memAddr_q <= nextAddr_d;
                     memRdEn_q <= 1'b1;
                  end
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (stop) stopPend_q <= 1'b1;
               if (dataVld_d) pfData_q <= memData;
               if (frameDone_d) begin
                  if (lastFrame_d) begin
                     csN_q      <= 1'b1;
                     done_q     <= 1'b1;
                     busy_q     <= 1'b0;
                     stopPend_q <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     // Prefetched byte becomes the current frame; fetch the one after it.
                     curAddr_q <= memAddr_q;
                     if (!noPf_d) begin
                        memAddr_q <= nextAddr_d;
                        memRdEn_q <= 1'b1;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_stream_sequencer.sv
// ============================================================================
// Module  : tb_spi_stream_sequencer
// Purpose : Directed self-checking bench for spi_stream_sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_stream_sequencer;

   localparam int MEM_LAT = 1;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        sclkPosEdge = 1'b0, sclkNegEdge = 1'b0;
   logic        start = 1'b0, stop = 1'b0;
   logic        loopEn = 1'b0;
   logic [15:0] startAddr = '0, endAddr = '0;
   logic [15:0] memAddr;
   logic        memRdEn;
   logic [7:0]  memData;
   logic        mosi, csN, busy, done;

   logic [7:0]  mem [0:65535];
   logic [7:0]  pipe [0:MEM_LAT-1];

   int          n_cmp = 0, n_err = 0;
   logic        mon_clr = 1'b0;
   logic [63:0] bits;
   int          nbits, n_rd, ndone, nrise;
   logic        csN_prev;
   logic [15:0] rd_log [0:15];

   spi_stream_sequencer #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(MEM_LAT)) dut (
      .clk         (clk),
      .resetN      (resetN),
      .sclkPosEdge (sclkPosEdge),
      .sclkNegEdge (sclkNegEdge),
      .start       (start),
      .stop        (stop),
`ifdef SPI_SEQ_LOOP_EN
      .loopEn      (loopEn),
`endif
      .startAddr   (startAddr),
      .endAddr     (endAddr),
      .memAddr     (memAddr),
      .memRdEn     (memRdEn),
      .memData     (memData),
      .mosi        (mosi),
      .csN         (csN),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Synchronous memory with MEM_LAT read pipeline.
   always @(posedge clk) begin
      if (memRdEn) pipe[0] <= mem[memAddr];
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign memData = pipe[MEM_LAT-1];

   // sclk divider model: period 8 clk, rising strobe at phase 0, falling at phase 4.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         sclkPosEdge = (ph == 0);
         sclkNegEdge = (ph == 4);
         ph = (ph + 1) % 8;
      end
   end

   // Slave-side observer.
   always @(negedge clk) begin
      if (mon_clr) begin
         bits <= '0; nbits <= 0; n_rd <= 0; ndone <= 0; nrise <= 0; csN_prev <= 1'b1;
      end else begin
         csN_prev <= csN;
         if (sclkPosEdge && !csN) begin
            bits  <= {bits[62:0], mosi};
            nbits <= nbits + 1;
         end
         if (memRdEn) begin
            if (n_rd < 16) rd_log[n_rd] <= memAddr;
            n_rd <= n_rd + 1;
         end
         if (done) ndone <= ndone + 1;
         if (!csN_prev && csN) nrise <= nrise + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic mon_reset();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   task automatic pulse_start(input logic [15:0] sa, input logic [15:0] ea);
      @(posedge clk); #1;
      startAddr = sa; endAddr = ea; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
   endtask

   task automatic wait_bits(input int n);
      int cyc;
      cyc = 0;
      while (nbits < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      if (nbits < n) chk("timeout_bits", 32'(nbits), 32'(n));
   endtask

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      while (busy && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk("idle_reached", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h3C; mem[16'h0012] = 8'hFF;
      mem[16'hFFFE] = 8'h12; mem[16'hFFFF] = 8'h81;
      mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h56;
      mem[16'h0020] = 8'hC3; mem[16'h0021] = 8'h0F;

      repeat (3) @(posedge clk);
      #2;
      chk("rst_csN",     {31'd0, csN},     32'd1);
      chk("rst_busy",    {31'd0, busy},    32'd0);
      chk("rst_mosi",    {31'd0, mosi},    32'd0);
      chk("rst_memRdEn", {31'd0, memRdEn}, 32'd0);
      chk("rst_memAddr", {16'd0, memAddr}, 32'd0);
      resetN = 1'b1;
      mon_reset();

      // Three-byte one-shot stream.
      pulse_start(16'h0010, 16'h0012);
      wait_idle();
      chk("a_nbits", 32'(nbits), 32'd24);
      chk("a_bits",  bits[31:0], 32'h00A53CFF);
      chk("a_nrd",   32'(n_rd), 32'd3);
      chk("a_rd0",   {16'd0, rd_log[0]}, 32'h0010);
      chk("a_rd1",   {16'd0, rd_log[1]}, 32'h0011);
      chk("a_rd2",   {16'd0, rd_log[2]}, 32'h0012);
      chk("a_done",  32'(ndone), 32'd1);
      chk("a_csrise", 32'(nrise), 32'd1);
      chk("a_csN",   {31'd0, csN}, 32'd1);
      mon_reset();

      // Single frame at the top of the address space.
      pulse_start(16'hFFFF, 16'hFFFF);
      wait_idle();
      chk("b_nbits", 32'(nbits), 32'd8);
      chk("b_bits",  bits[31:0], 32'h00000081);
      chk("b_nrd",   32'(n_rd), 32'd1);
      chk("b_rd0",   {16'd0, rd_log[0]}, 32'hFFFF);
      chk("b_done",  32'(ndone), 32'd1);
      mon_reset();

      // Wrap across FFFF -> 0000.
      pulse_start(16'hFFFE, 16'h0001);
      wait_idle();
      chk("c_nbits", 32'(nbits), 32'd32);
      chk("c_bits",  bits[31:0], 32'h12813456);
      chk("c_nrd",   32'(n_rd), 32'd4);
      chk("c_rd0",   {16'd0, rd_log[0]}, 32'hFFFE);
      chk("c_rd1",   {16'd0, rd_log[1]}, 32'hFFFF);
      chk("c_rd2",   {16'd0, rd_log[2]}, 32'h0000);
      chk("c_rd3",   {16'd0, rd_log[3]}, 32'h0001);
      chk("c_done",  32'(ndone), 32'd1);
      mon_reset();

      // Graceful stop inside frame 1.
      pulse_start(16'h0010, 16'h0012);
      wait_bits(3);
      pulse_stop();
      wait_idle();
      chk("d_nbits", 32'(nbits), 32'd8);
      chk("d_bits",  bits[31:0], 32'h000000A5);
      chk("d_done",  32'(ndone), 32'd1);
      mon_reset();

      // Asynchronous reset mid-frame.
      pulse_start(16'h0010, 16'h0012);
      wait_bits(4);
      #2 resetN = 1'b0;
      #1;
      chk("e_csN",  {31'd0, csN},  32'd1);
      chk("e_mosi", {31'd0, mosi}, 32'd0);
      chk("e_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1 resetN = 1'b1;
      mon_reset();

      // Start while busy is ignored.
      pulse_start(16'h0010, 16'h0012);
      wait_bits(5);
      pulse_start(16'h0020, 16'h0020);
      wait_idle();
      chk("f_nbits", 32'(nbits), 32'd24);
      chk("f_bits",  bits[31:0], 32'h00A53CFF);
      chk("f_nrd",   32'(n_rd), 32'd3);
      chk("f_done",  32'(ndone), 32'd1);
      mon_reset();

      // Start and stop together in IDLE: stop wins.
      @(posedge clk); #1;
      startAddr = 16'h0010; endAddr = 16'h0012; start = 1'b1; stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      @(negedge clk);
      chk("g_busy", {31'd0, busy}, 32'd0);
      chk("g_nrd",  32'(n_rd), 32'd0);

`ifdef SPI_SEQ_LOOP_EN
      mon_reset();
      loopEn = 1'b1;
      pulse_start(16'h0020, 16'h0021);
      loopEn = 1'b0;
      wait_bits(26);
      pulse_stop();
      wait_idle();
      chk("h_nbits", 32'(nbits), 32'd32);
      chk("h_bits",  bits[31:0], 32'hC30FC30F);
      chk("h_done",  32'(ndone), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
